// File: rtl/xgmii_rx_deframer.sv
// Purpose: strips XGMII Start/Terminate framing into a 64-bit word stream with keep/sop/eop/err and frame counters.
// Latency: a data word on XGMII in cycle t is visible on rx_data in cycle t+2.
// Backpressure: rx_ready stalls a show-ahead output FIFO; a push into a full FIFO drops the rest of the frame.

// Purpose: small show-ahead FIFO, read data valid whenever not empty.
// Latency: a word pushed at a clock edge is readable right after that edge.
// Backpressure: caller must not push when full unless it pops in the same cycle.
module xgmii_rx_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push_vld,
    input  logic [W-1:0] push_dat,
    input  logic         pop,
    output logic [W-1:0] rd_dat,
    output logic         empty,
    output logic         full
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;

    // storage array carries no reset; its contents are qualified by count
    always_ff @(posedge clk) begin
        if (push_vld) mem[wr_ptr] <= push_dat;
    end

    // pointer and occupancy tracking
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_vld) wr_ptr <= wr_ptr + AW'(1);
            if (pop)      rd_ptr <= rd_ptr + AW'(1);
            case ({push_vld, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    assign rd_dat = mem[rd_ptr];
    assign empty  = (count == '0);
    assign full   = (count == FULL_CNT);
endmodule

module xgmii_rx_deframer #(
    parameter int FIFO_DEPTH = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [63:0] xgmii_rxd,
    input  logic [7:0]  xgmii_rxc,
    output logic        rx_valid,
    output logic [63:0] rx_data,
    output logic [7:0]  rx_keep,
    output logic        rx_sop,
    output logic        rx_eop,
    output logic        rx_err,
    input  logic        rx_ready,
    output logic [15:0] rx_packet_count,
    output logic [15:0] rx_error_count,
    output logic [15:0] rx_drop_count
);
    typedef struct packed {
        logic [63:0] dat;
        logic [7:0]  keep;
        logic        sop;
        logic        eop;
        logic        err;
    } word_t;

    typedef enum logic [1:0] {IDLE, FRAME, DRAIN, DROP} state_t;

    state_t      state;
    logic [63:0] hold_dat;
    logic [7:0]  hold_keep;
    logic        hold_vld;
    logic        sop_pending;
    logic        abort_pending;

    logic        is_start, is_data, is_term;
    logic [2:0]  term_k;
    logic [7:0]  part_keep;
    logic [63:0] part_dat;

    word_t       push_word, rd_word;
    logic        frame_push, marker_push, push_vld, frame_drop, space, pop;
    logic        fifo_empty, fifo_full, err_evt;

    // decode the XGMII word: Start, plain data, or Terminate at the lowest flagged lane
    always_comb begin
        term_k = 3'd0;
        for (int k = 7; k >= 0; k--) begin
            if (xgmii_rxc[k]) term_k = 3'(k);
        end
        is_start  = (xgmii_rxc == 8'h01) && (xgmii_rxd[7:0] == 8'hFB);
        is_data   = (xgmii_rxc == 8'h00);
        is_term   = !is_data && (xgmii_rxd[{term_k, 3'b000} +: 8] == 8'hFD);
        part_keep = (8'h01 << term_k) - 8'h01;
        part_dat  = '0;
        for (int i = 0; i < 8; i++) begin
            if (part_keep[i]) part_dat[8*i +: 8] = xgmii_rxd[8*i +: 8];
        end
    end

    assign pop   = rx_valid && rx_ready;
    assign space = !fifo_full || pop;

    // choose this cycle's single FIFO push: held word first, abort marker only when the slot is free
    always_comb begin
        frame_push     = 1'b0;
        push_word.dat  = hold_dat;
        push_word.keep = hold_keep;
        push_word.sop  = sop_pending;
        push_word.eop  = 1'b0;
        push_word.err  = 1'b0;
        case (state)
            FRAME: begin
                frame_push    = hold_vld;
                push_word.eop = !is_data && !(is_term && term_k != 3'd0);
                push_word.err = !is_data && !is_term;
            end
            DRAIN: begin
                frame_push    = 1'b1;
                push_word.eop = 1'b1;
            end
            default: frame_push = 1'b0;
        endcase
        marker_push = abort_pending && !frame_push && space;
        if (marker_push) begin
            push_word.dat  = '0;
            push_word.keep = 8'h00;
            push_word.sop  = 1'b0;
            push_word.eop  = 1'b1;
            push_word.err  = 1'b1;
        end
        frame_drop = frame_push && !space;
        push_vld   = (frame_push && space) || marker_push;
        err_evt    = (state == FRAME) && !frame_drop &&
                     ((!is_data && !is_term) || (is_term && term_k == 3'd0 && !hold_vld));
    end

    // frame state machine and one-word hold register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            hold_dat      <= '0;
            hold_keep     <= '0;
            hold_vld      <= 1'b0;
            sop_pending   <= 1'b0;
            abort_pending <= 1'b0;
        end else begin
            if (marker_push)                abort_pending <= 1'b0;
            if (frame_drop && !sop_pending) abort_pending <= 1'b1;
            if (frame_push && space)        sop_pending   <= 1'b0;
            case (state)
                IDLE: if (is_start) begin
                    state       <= FRAME;
                    sop_pending <= 1'b1;
                    hold_vld    <= 1'b0;
                end
                FRAME: begin
                    if (frame_drop) begin
                        state    <= DROP;
                        hold_vld <= 1'b0;
                    end else if (is_data) begin
                        hold_vld  <= 1'b1;
                        hold_dat  <= xgmii_rxd;
                        hold_keep <= 8'hFF;
                    end else if (is_term && term_k != 3'd0) begin
                        hold_vld  <= 1'b1;
                        hold_dat  <= part_dat;
                        hold_keep <= part_keep;
                        state     <= DRAIN;
                    end else begin
                        hold_vld <= 1'b0;
                        state    <= IDLE;
                    end
                end
                DRAIN: begin
                    hold_vld <= 1'b0;
                    if (is_start) begin
                        state       <= FRAME;
                        sop_pending <= 1'b1;
                    end else if (frame_drop) begin
                        state <= DROP;
                    end else begin
                        state <= IDLE;
                    end
                end
                DROP: begin
                    if (is_start) begin
                        state       <= FRAME;
                        sop_pending <= 1'b1;
                    end else if (xgmii_rxc != 8'h00) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'h0001;
    endfunction

    // saturating frame statistics
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_packet_count <= '0;
            rx_error_count  <= '0;
            rx_drop_count   <= '0;
        end else begin
            if (push_vld && push_word.eop && !push_word.err)
                rx_packet_count <= sat_inc(rx_packet_count);
            if (err_evt)    rx_error_count <= sat_inc(rx_error_count);
            if (frame_drop) rx_drop_count  <= sat_inc(rx_drop_count);
        end
    end

    xgmii_rx_fifo #(
        .W     ($bits(word_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push_vld (push_vld),
        .push_dat (push_word),
        .pop      (pop),
        .rd_dat   (rd_word),
        .empty    (fifo_empty),
        .full     (fifo_full)
    );

    assign rx_valid = !fifo_empty;
    assign rx_data  = rx_valid ? rd_word.dat  : 64'h0;
    assign rx_keep  = rx_valid ? rd_word.keep : 8'h00;
    assign rx_sop   = rx_valid && rd_word.sop;
    assign rx_eop   = rx_valid && rd_word.eop;
    assign rx_err   = rx_valid && rd_word.err;
endmodule

// File: tb/tb_xgmii_rx_deframer.sv
// Purpose: self-checking bench for xgmii_rx_deframer using a frame-level expected-word queue.
// Latency: expectations are consumed in order as words transfer on rx_valid && rx_ready.
// Backpressure: rx_ready is held low or toggled in a fixed pattern to exercise stalls and overflow.
module tb_xgmii_rx_deframer;
    localparam logic [63:0] IDLE_D  = {8{8'h07}};
    localparam logic [63:0] START_D = 64'hD5555555555555FB;

    typedef struct packed {
        logic [63:0] dat;
        logic [7:0]  keep;
        logic        sop;
        logic        eop;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [63:0] xgmii_rxd;
    logic [7:0]  xgmii_rxc;
    logic        rx_valid, rx_sop, rx_eop, rx_err, rx_ready;
    logic [63:0] rx_data;
    logic [7:0]  rx_keep;
    logic [15:0] rx_packet_count, rx_error_count, rx_drop_count;

    exp_t exp_q[$];
    exp_t cur, e_cmp, prev_out, last_word;
    logic stall_prev = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   term_cyc = 0;
    int   last_eop_cyc = -1;
    int   exp_pkt = 0, exp_err = 0, exp_drop = 0;

    always #5 clk = ~clk;

    xgmii_rx_deframer #(.FIFO_DEPTH(4)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .xgmii_rxd       (xgmii_rxd),
        .xgmii_rxc       (xgmii_rxc),
        .rx_valid        (rx_valid),
        .rx_data         (rx_data),
        .rx_keep         (rx_keep),
        .rx_sop          (rx_sop),
        .rx_eop          (rx_eop),
        .rx_err          (rx_err),
        .rx_ready        (rx_ready),
        .rx_packet_count (rx_packet_count),
        .rx_error_count  (rx_error_count),
        .rx_drop_count   (rx_drop_count)
    );

    always @(posedge clk) cyc = cyc + 1;

    task automatic check(input string name, input logic [79:0] act, input logic [79:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // compare process: every transferred word against the model queue, stalled outputs held steady
    always @(negedge clk) begin
        if (rst_n !== 1'b1) begin
            stall_prev = 1'b0;
        end else begin
            cur = {rx_data, rx_keep, rx_sop, rx_eop, rx_err};
            if (stall_prev && rx_valid) check("stall_stable", cur, prev_out);
            if (rx_valid && rx_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_word: got %h expected none", cur);
                end else begin
                    e_cmp = exp_q.pop_front();
                    check("out_word", cur, e_cmp);
                end
                if (rx_eop) begin
                    last_eop_cyc = cyc;
                    last_word    = cur;
                end
            end
            stall_prev = rx_valid && !rx_ready;
            prev_out   = cur;
        end
    end

    task automatic drive(input logic [63:0] d, input logic [7:0] c);
        @(posedge clk);
        #1;
        xgmii_rxd = d;
        xgmii_rxc = c;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(IDLE_D, 8'hFF);
    endtask

    // frame of nbytes with byte i = seed+i; ends in Terminate, or in an FE error lane when err_end
    task automatic send_frame(input int nbytes, input logic [7:0] seed, input bit err_end);
        int nw, r, nout, cnt;
        logic [63:0] w;
        logic [7:0]  c;
        exp_t e;
        nw   = nbytes / 8;
        r    = nbytes % 8;
        nout = err_end ? nw : (nbytes + 7) / 8;
        if (nout == 0) begin
            exp_err++;
        end else begin
            for (int i = 0; i < nout; i++) begin
                cnt = nbytes - 8 * i;
                if (cnt > 8) cnt = 8;
                e = '0;
                for (int j = 0; j < cnt; j++) e.dat[8*j +: 8] = seed + 8'(8 * i + j);
                e.keep = 8'((16'h1 << cnt) - 16'h1);
                e.sop  = (i == 0);
                e.eop  = (i == nout - 1);
                e.err  = err_end && (i == nout - 1);
                exp_q.push_back(e);
            end
            if (err_end) exp_err++;
            else         exp_pkt++;
        end
        drive(START_D, 8'h01);
        for (int i = 0; i < nw; i++) begin
            for (int j = 0; j < 8; j++) w[8*j +: 8] = seed + 8'(8 * i + j);
            drive(w, 8'h00);
        end
        w = IDLE_D;
        if (err_end) begin
            w[23:16] = 8'hFE;
            c = 8'h04;
        end else begin
            for (int j = 0; j < r; j++) w[8*j +: 8] = seed + 8'(8 * nw + j);
            w[8*r +: 8] = 8'hFD;
            c = 8'hFF << r;
        end
        drive(w, c);
        term_cyc = cyc;
    endtask

    task automatic check_counters(input string tag);
        check({tag, "_pkt"},  rx_packet_count, exp_pkt);
        check({tag, "_err"},  rx_error_count,  exp_err);
        check({tag, "_drop"}, rx_drop_count,   exp_drop);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] pat;
        logic [63:0] w;
        exp_t e;
        rst_n     = 1'b0;
        rx_ready  = 1'b0;
        xgmii_rxd = IDLE_D;
        xgmii_rxc = 8'hFF;
        repeat (3) @(posedge clk);
        #2;
        check("rst_valid", rx_valid, 0);
        check("rst_data",  rx_data, 0);
        check("rst_flags", {rx_keep, rx_sop, rx_eop, rx_err}, 0);
        check_counters("rst");
        rst_n    = 1'b1;
        rx_ready = 1'b1;
        idle(2);

        // three full words, Terminate in lane 0
        send_frame(24, 8'h00, 1'b0);
        idle(4);
        check("k0_latency", last_eop_cyc, term_cyc + 1);
        check("k0_pkt_lit", rx_packet_count, 1);

        // one full word then A,B,C before Terminate in lane 3
        send_frame(11, 8'h10, 1'b0);
        idle(4);
        check("k3_latency", last_eop_cyc, term_cyc + 2);
        check("k3_word_lit", last_word, {64'h00000000001A1918, 8'h07, 1'b0, 1'b1, 1'b0});

        // two words then an FE error lane
        send_frame(16, 8'h20, 1'b1);
        idle(4);
        check("errframe_err_lit", rx_error_count, 1);
        check("errframe_pkt_lit", rx_packet_count, 2);

        // runt: Start immediately followed by Terminate
        send_frame(0, 8'h00, 1'b0);
        idle(4);
        check("runt_err_lit", rx_error_count, 2);
        check_counters("basic");

        // assorted lengths; 9-byte frame's DRAIN cycle meets the next Start
        send_frame(8, 8'h30, 1'b0);
        idle(2);
        send_frame(9, 8'h40, 1'b0);
        send_frame(15, 8'h50, 1'b0);
        idle(3);
        send_frame(23, 8'h60, 1'b0);
        idle(4);
        check_counters("mixed");

        // stalls with a fixed ready pattern
        pat = 32'hB6DB6DB6;
        fork
            begin
                send_frame(20, 8'h70, 1'b0);
                idle(2);
                send_frame(17, 8'h80, 1'b0);
                idle(4);
            end
            begin
                for (int i = 0; i < 32; i++) begin
                    @(posedge clk);
                    #1;
                    rx_ready = pat[i];
                end
                rx_ready = 1'b1;
            end
        join
        idle(6);
        check_counters("stall");
        check("stall_drained", exp_q.size(), 0);

        // overflow: eight words into a four-deep FIFO with the consumer stalled
        rx_ready = 1'b0;
        drive(START_D, 8'h01);
        for (int i = 0; i < 8; i++) drive({56'hA5A5A5A5A5A5A5, 8'(i)}, 8'h00);
        drive({IDLE_D[63:8], 8'hFD}, 8'hFF);
        idle(3);
        exp_drop = 1;
        check("ovf_valid", rx_valid, 1);
        check("ovf_drop_lit", rx_drop_count, 1);
        for (int i = 0; i < 4; i++) begin
            e.dat  = {56'hA5A5A5A5A5A5A5, 8'(i)};
            e.keep = 8'hFF;
            e.sop  = (i == 0);
            e.eop  = 1'b0;
            e.err  = 1'b0;
            exp_q.push_back(e);
        end
        e = {64'h0, 8'h00, 1'b0, 1'b1, 1'b1};
        exp_q.push_back(e);
        rx_ready = 1'b1;
        idle(10);
        check("ovf_drained", exp_q.size(), 0);
        check_counters("ovf");

        // reset while two words sit in the FIFO
        rx_ready = 1'b0;
        drive(START_D, 8'h01);
        for (int i = 0; i < 4; i++) drive({56'h0123456789ABCD, 8'(i)}, 8'h00);
        #2;
        check("pre_rst_valid", rx_valid, 1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", rx_valid, 0);
        exp_pkt  = 0;
        exp_err  = 0;
        exp_drop = 0;
        exp_q.delete();
        check_counters("mid_rst");
        xgmii_rxd = IDLE_D;
        xgmii_rxc = 8'hFF;
        @(posedge clk);
        #1;
        rst_n    = 1'b1;
        rx_ready = 1'b1;
        idle(2);
        send_frame(19, 8'h90, 1'b0);
        idle(5);
        check_counters("post_rst");

        for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(posedge clk);
        check("final_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/xgmii_rx_deframer.md
XGMII_RX_DEFRAMER -- requirements
Module: xgmii_rx_deframer

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 16, output FIFO depth in 64-bit words (power of 2, >=4).
REQ-002 SHALL have ports, in this order:
- clk  in  1  sole clock.
- rst_n  in  1  asynchronous active-low reset.
- xgmii_rxd  in  64  XGMII data, lane k = bits [8k+7:8k].
- xgmii_rxc  in  8  XGMII control, bit k flags lane k.
- rx_valid  out  1  output word available.
- rx_data  out  64  frame bytes, lane 0 first.
- rx_keep  out  8  valid-byte mask, contiguous from lane 0.
- rx_sop  out  1  first word of frame.
- rx_eop  out  1  last word of frame.
- rx_err  out  1  frame errored (qualified by rx_eop).
- rx_ready  in  1  consumer accepts word.
- rx_packet_count  out  16  good frames delivered.
- rx_error_count  out  16  errored/runt frames.
- rx_drop_count  out  16  frames truncated by FIFO overflow.
REQ-003 SHALL use one clock; reset is asynchronous and active-low.

Function
REQ-004 SHALL define Start as rxc=8'h01 with rxd[7:0]=8'hFB; lanes 1-7 (preamble/SFD) are discarded.
REQ-005 SHALL define Terminate at lane k as rxc[k]=1, lane k=8'hFD, rxc bits below k =0; lanes <k are data (k bytes).
REQ-006 SHALL define data word as rxc=8'h00, 8 bytes.
REQ-007 SHALL use states IDLE, FRAME, DRAIN, DROP; reset -> IDLE.
REQ-008 IDLE: Start -> FRAME, sop_pending=1; all else ignored.
REQ-009 FRAME: each data word is loaded into a one-word hold register; prior held word, if any, is pushed with eop=0.
REQ-010 FRAME, Terminate k=0: held word pushed with eop=1, keep=8'hFF -> IDLE.
REQ-011 FRAME, Terminate k>0: held word pushed eop=0; partial word loaded to hold with keep=(1<<k)-1, eop=1 -> DRAIN.
REQ-012 DRAIN: held word pushed unconditionally -> IDLE; a Start in this same cycle SHALL be accepted (-> FRAME) with no push conflict.
REQ-013 FRAME, any other nonzero rxc (incl. 8'hFE error, Start, malformed Terminate): held word pushed eop=1, err=1; rx_error_count+1 -> IDLE.
REQ-014 Terminate/error with no data yet received (runt): nothing pushed, rx_error_count+1 -> IDLE.
REQ-015 First pushed word of a frame SHALL carry sop=1; sop and eop may be set together.
REQ-016 At most one FIFO push per cycle.
REQ-017 Push while FIFO full: word discarded, rx_drop_count+1 -> DROP; if the frame had already pushed a word, abort_pending=1.
REQ-018 DROP: discard all input until Terminate or nonzero non-Start rxc -> IDLE; a Start while in DROP -> FRAME.
REQ-019 abort_pending: push marker word keep=8'h00, eop=1, err=1 in first cycle FIFO not full and no other push; then clear.
REQ-020 Output: show-ahead FIFO; rx_valid = FIFO not empty; word transfers when rx_valid && rx_ready; rx_data/keep/sop/eop/err stable while rx_valid && !rx_ready.
REQ-021 Latency: data word on XGMII cycle t is pushed at end of t+1 (end of t for k=0 Terminate case) and visible on rx_data at t+2.
REQ-022 Simultaneous push and pop on full FIFO: pop frees space first; push accepted.
REQ-023 rx_packet_count +1 when an eop=1, err=0 word is pushed.
REQ-024 All counters SHALL saturate at 16'hFFFF.

Reset
REQ-025 rst_n low SHALL asynchronously force: state IDLE, hold/sop_pending/abort_pending cleared, FIFO empty, rx_valid=0, rx_data=0, rx_keep=0, rx_sop=0, rx_eop=0, rx_err=0, all counters 0.
REQ-026 Reset mid-frame SHALL discard partial frame; no eop emitted afterwards for it.

Verification
REQ-027 Start; 3 data words D0-D2; Terminate k=0; rx_ready=1 -> 3 words, sop on D0, eop on D2, keep 8'hFF, packet_count=1.
REQ-028 Start; D0; Terminate k=3 with bytes A,B,C -> D0 (sop, keep FF), then {C,B,A} keep 8'h07 eop=1; partial word valid 2 cycles after Terminate.
REQ-029 Start; D0; D1; word with lane2=8'hFE rxc=8'h04 -> D0 sop, D1 eop=1 err=1; error_count=1, packet_count=0.
REQ-030 Start; Terminate k=0 -> no output; error_count=1.
REQ-031 FIFO_DEPTH=4, rx_ready=0, 8-word frame -> 4 words stored, drop_count=1; then rx_ready=1 -> 4 words then marker keep 8'h00 eop=1 err=1.
REQ-032 rst_n low mid-frame with FIFO holding 2 words -> rx_valid=0 immediately, counters 0; next complete frame delivered normally.
